instr_encoder_loader: RTL and testbench
=======================================

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the word-address width of the instruction-memory write port.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse that opens a load session.
REQ-005 base_addr  input  ADDR_W  first word address of the session, sampled on start.
REQ-006 in_valid  input  1  field bundle valid.
REQ-007 in_ready  output  1  encoder can accept a bundle.
REQ-008 in_last  input  1  the bundle is the final one of the session.
REQ-009 opcode  input  7, rd  input  5, funct3  input  3, rs1  input  5, rs2  input  5, funct7  input  7, imm  input  32  decoded-field bundle, with imm sign-extended as the decode stage produces it.
REQ-010 mem_we  output  1  instruction-memory write strobe (valid).
REQ-011 mem_ack  input  1  the memory accepts the write this cycle.
REQ-012 mem_addr  output  ADDR_W  word address; mem_wdata  output  32  encoded instruction.
REQ-013 busy  output  1, done  output  1  one-cycle end-of-session pulse; word_count  output  ADDR_W+1  words written this session.
REQ-014 err  output  1  sticky error flag; err_code  output  2  code of the most recent error.

Function
REQ-015 The encoder SHALL select the format from opcode: R 0110011; I 0010011/0000011/1100111; S 0100011; B 1100011; U 0110111/0010111; J 1101111.
REQ-016 R SHALL encode {funct7,rs2,rs1,funct3,rd,opcode}; I SHALL encode {imm[11:0],rs1,funct3,rd,opcode}; S SHALL encode {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-017 B SHALL encode {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U SHALL encode {imm[31:12],rd,opcode}; J SHALL encode {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}; fields unused by a format SHALL be ignored.
REQ-018 Range checks: I/S require imm[31:11] all equal; B requires imm[0]=0 and imm[31:12] all equal; J requires imm[0]=0 and imm[31:20] all equal; U requires imm[11:0]=0.
REQ-019 Error codes: 1 unsupported opcode, 2 immediate out of range, 3 address space exhausted; priority 1>2>3; an erroring bundle SHALL be consumed and dropped, SHALL set err, and SHALL load err_code.
REQ-020 FSM states: IDLE, RUN, DRAIN, DONE; busy=1 in RUN and DRAIN.
REQ-021 IDLE: in_ready=0; start moves to RUN, loads the address counter with base_addr, clears word_count, err and err_code.
REQ-022 RUN: in_ready = !mem_we || mem_ack (single output register); a bundle is accepted when in_valid && in_ready.
REQ-023 An accepted legal bundle SHALL drive mem_we=1, mem_addr=counter and mem_wdata=encoding on the next cycle (latency 1), holding all three stable until mem_ack.
REQ-024 On each mem_ack the counter and word_count SHALL increment; a write at address 2^ADDR_W-1 SHALL set an internal full flag instead of wrapping, and subsequent legal bundles SHALL take error code 3.
REQ-025 An accepted bundle with in_last=1 (legal or erroring) SHALL move the FSM to DRAIN; DRAIN SHALL hold in_ready=0 until no write is pending, then go to DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE; word_count, err and err_code SHALL hold until the next start.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 An accept and a mem_ack in the same cycle SHALL retire the old word and load the new one with no bubble.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and clear mem_we, mem_addr, mem_wdata, in_ready, busy, done, word_count, err, err_code and the full flag to 0, including when a write is pending (the pending write is discarded).

Verification
REQ-030 Scenario: start with base_addr=0x010, then addi x1,x0,5 (imm=5) with mem_ack held 1 -> mem_addr=0x010 and mem_wdata=0x00500093 one cycle after accept.
REQ-031 Scenario: back-to-back add x3,x1,x2 / beq x1,x2,+8 / jal x1,+2048 / lui x5,0x12345000 (last) -> words 0x002081B3, 0x00208463, 0x001000EF and 0x123452B7 at consecutive addresses; word_count=4; a single done pulse.
REQ-032 Scenario: mem_ack held 0 for 3 cycles with a write pending -> in_ready=0 and mem_addr/mem_wdata stable; the word retires on the first mem_ack.
REQ-033 Scenario: opcode 0x7F, then an I-type with imm=0x800 -> both dropped, no mem_we, err=1, err_code=2 after the second.
REQ-034 Scenario: ADDR_W=2, base_addr=3, two legal bundles -> the first is written at 3; the second is dropped with err_code=3; word_count=1.
REQ-035 Scenario: rst_n pulsed low while mem_we=1 -> mem_we falls asynchronously, the FSM is in IDLE, and all outputs read 0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes decoded RV32I field bundles and streams them into instruction memory
// Session FSM with a single write register; erroring bundles are consumed and dropped.
module instr_encoder_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_OPC   = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_FULL  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_mem_wdata;
  logic [ADDR_W:0]     r_word_count;
  logic                r_err;
  logic [1:0]          r_err_code;
  logic                r_full;

  logic                w_fmt_ok;
  logic                w_imm_ok;
  logic [31:0]         w_enc;
  logic                w_i_ok;
  logic                w_b_ok;
  logic                w_j_ok;
  logic                w_u_ok;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_retire;
  logic                w_at_top;
  logic                w_full_now;
  logic [1:0]          w_code;
  logic                w_load;
  logic                w_open;

  // Immediate must be representable by the field width the format carries.
  assign w_i_ok = (&imm[31:11]) || !(|imm[31:11]);
  assign w_b_ok = !imm[0] && ((&imm[31:12]) || !(|imm[31:12]));
  assign w_j_ok = !imm[0] && ((&imm[31:20]) || !(|imm[31:20]));
  assign w_u_ok = !(|imm[11:0]);

  always_comb begin
    w_fmt_ok = 1'b1;
    w_imm_ok = 1'b1;
    w_enc    = 32'd0;
    case (opcode)
      OP_R: begin
        w_enc = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        w_enc    = {imm[11:0], rs1, funct3, rd, opcode};
        w_imm_ok = w_i_ok;
      end
      OP_STORE: begin
        w_enc    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        w_imm_ok = w_i_ok;
      end
      OP_BRANCH: begin
        w_enc    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        w_imm_ok = w_b_ok;
      end
      OP_LUI, OP_AUIPC: begin
        w_enc    = {imm[31:12], rd, opcode};
        w_imm_ok = w_u_ok;
      end
      OP_JAL: begin
        w_enc    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        w_imm_ok = w_j_ok;
      end
      default: begin
        w_fmt_ok = 1'b0;
      end
    endcase
  end

  assign w_in_ready = (r_state == S_RUN) && (!r_mem_we || mem_ack);
  assign w_accept   = in_valid && w_in_ready;
  assign w_retire   = r_mem_we && mem_ack;
  assign w_at_top   = &r_addr;
  assign w_open     = (r_state == S_IDLE) && start;

  // A retire at the top address this cycle already exhausts the space for a bundle accepted alongside it.
  assign w_full_now = r_full || (w_retire && w_at_top);

  always_comb begin
    w_code = ERR_NONE;
    if (!w_fmt_ok) begin
      w_code = ERR_OPC;
    end else if (!w_imm_ok) begin
      w_code = ERR_RANGE;
    end else if (w_full_now) begin
      w_code = ERR_FULL;
    end
  end

  assign w_load = w_accept && (w_code == ERR_NONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_accept && in_last) w_next = S_DRAIN;
      S_DRAIN: if (!r_mem_we || mem_ack) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we     <= 1'b0;
      r_addr       <= '0;
      r_mem_wdata  <= 32'd0;
      r_word_count <= '0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_full       <= 1'b0;
    end else begin
      if (w_open) begin
        r_addr       <= base_addr;
        r_word_count <= '0;
        r_err        <= 1'b0;
        r_err_code   <= ERR_NONE;
        r_full       <= 1'b0;
      end else begin
        if (w_retire) begin
          r_word_count <= r_word_count + (ADDR_W+1)'(1);
          if (w_at_top) begin
            r_full <= 1'b1;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        if (w_accept && (w_code != ERR_NONE)) begin
          r_err      <= 1'b1;
          r_err_code <= w_code;
        end
      end
      if (w_load) begin
        r_mem_we    <= 1'b1;
        r_mem_wdata <= w_enc;
      end else if (w_retire) begin
        r_mem_we <= 1'b0;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign word_count = r_word_count;
  assign err        = r_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed vector bench for instr_encoder_loader
// Instance a uses ADDR_W=10; instance b uses ADDR_W=2 for address-exhaustion sessions.
module tb_instr_encoder_loader;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          mem_ack = 1'b0;
  logic          use2 = 1'b0;
  logic [6:0]    opcode = '0;
  logic [4:0]    rd = '0;
  logic [2:0]    funct3 = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [6:0]    funct7 = '0;
  logic [31:0]   imm = '0;

  logic          a_start, a_in_valid, a_in_ready, a_mem_we, a_busy, a_done, a_err;
  logic [AW-1:0] a_mem_addr;
  logic [31:0]   a_mem_wdata;
  logic [AW:0]   a_word_count;
  logic [1:0]    a_err_code;

  logic          b_start, b_in_valid, b_in_ready, b_mem_we, b_busy, b_done, b_err;
  logic [1:0]    b_mem_addr;
  logic [31:0]   b_mem_wdata;
  logic [2:0]    b_word_count;
  logic [1:0]    b_err_code;

  assign a_start    = start && !use2;
  assign b_start    = start && use2;
  assign a_in_valid = in_valid && !use2;
  assign b_in_valid = in_valid && use2;

  logic w_rdy, w_done;
  assign w_rdy  = use2 ? b_in_ready : a_in_ready;
  assign w_done = use2 ? b_done : a_done;

  instr_encoder_loader #(.ADDR_W(AW)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .base_addr(base_addr),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_last(in_last),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .mem_we(a_mem_we), .mem_ack(mem_ack),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .busy(a_busy),
    .done(a_done), .word_count(a_word_count), .err(a_err), .err_code(a_err_code)
  );

  instr_encoder_loader #(.ADDR_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .base_addr(base_addr[1:0]),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_last(in_last),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .mem_we(b_mem_we), .mem_ack(mem_ack),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .busy(b_busy),
    .done(b_done), .word_count(b_word_count), .err(b_err), .err_code(b_err_code)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [AW-1:0] q_addr[$];
  logic [31:0]   q_data[$];

  always @(posedge clk) begin
    if (a_done) done_cnt++;
    if (a_mem_we && mem_ack) begin
      q_addr.push_back(a_mem_addr);
      q_data.push_back(a_mem_wdata);
    end
  end

  typedef struct {
    string       nm;
    logic [6:0]  op;
    logic [4:0]  d;
    logic [2:0]  f3;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [6:0]  f7;
    logic [31:0] im;
    logic [1:0]  code;
    logic [31:0] wd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(input string nm, input logic [6:0] op, input logic [4:0] d,
                             input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                             input logic [6:0] f7, input logic [31:0] im, input logic [1:0] code,
                             input logic [31:0] wd);
    vec_t r;
    r.nm = nm; r.op = op; r.d = d; r.f3 = f3; r.s1 = s1; r.s2 = s2;
    r.f7 = f7; r.im = im; r.code = code; r.wd = wd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                            input logic [31:0] im);
    opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
  endtask

  task automatic resync();
    @(posedge clk);
    #1;
  endtask

  task automatic open_session(input logic [AW-1:0] b);
    start = 1'b1;
    base_addr = b;
    resync();
    start = 1'b0;
  endtask

  task automatic send(input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_last = last;
    @(negedge clk);
    while (!w_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_within_budget", w_rdy, 1);
    resync();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!w_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", w_done, 1);
    resync();
  endtask

  initial begin
    int wb;
    int db;
    logic [31:0] exp_w[4];

    tv.push_back(v("addi",      7'h13, 5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'd5,        2'd0, 32'h00500093));
    tv.push_back(v("sub",       7'h33, 5'd1,  3'd0, 5'd2,  5'd3,  7'h20, 32'hDEADBEEF, 2'd0, 32'h403100B3));
    tv.push_back(v("beq",       7'h63, 5'h1F, 3'd0, 5'd1,  5'd2,  7'h7F, 32'd8,        2'd0, 32'h00208463));
    tv.push_back(v("jal_2048",  7'h6F, 5'd1,  3'd7, 5'h1F, 5'h1F, 7'h7F, 32'h800,      2'd0, 32'h001000EF));
    tv.push_back(v("lui",       7'h37, 5'd5,  3'd0, 5'd0,  5'd0,  7'h00, 32'h12345000, 2'd0, 32'h123452B7));
    tv.push_back(v("sw_m4",     7'h23, 5'h0A, 3'd2, 5'd1,  5'd2,  7'h00, 32'hFFFFFFFC, 2'd0, 32'hFE20AE23));
    tv.push_back(v("lw_m2048",  7'h03, 5'd5,  3'd2, 5'd6,  5'd0,  7'h00, 32'hFFFFF800, 2'd0, 32'h80032283));
    tv.push_back(v("jalr",      7'h67, 5'd0,  3'd0, 5'd1,  5'd0,  7'h00, 32'd0,        2'd0, 32'h00008067));
    tv.push_back(v("auipc",     7'h17, 5'd10, 3'd0, 5'd0,  5'd0,  7'h00, 32'hFFFFF000, 2'd0, 32'hFFFFF517));
    tv.push_back(v("jal_m4",    7'h6F, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'hFFFFFFFC, 2'd0, 32'hFFDFF06F));
    tv.push_back(v("addi_2047", 7'h13, 5'd1,  3'd0, 5'd1,  5'd0,  7'h00, 32'h7FF,      2'd0, 32'h7FF08093));
    tv.push_back(v("addi_2048", 7'h13, 5'd1,  3'd0, 5'd1,  5'd0,  7'h00, 32'h800,      2'd2, 32'h0));
    tv.push_back(v("bne_odd",   7'h63, 5'd0,  3'd1, 5'd1,  5'd2,  7'h00, 32'd3,        2'd2, 32'h0));
    tv.push_back(v("b_4096",    7'h63, 5'd0,  3'd0, 5'd1,  5'd2,  7'h00, 32'h1000,     2'd2, 32'h0));
    tv.push_back(v("lui_low",   7'h37, 5'd5,  3'd0, 5'd0,  5'd0,  7'h00, 32'h800,      2'd2, 32'h0));
    tv.push_back(v("jal_big",   7'h6F, 5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00100000, 2'd2, 32'h0));
    tv.push_back(v("opc_7f",    7'h7F, 5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'd0,        2'd1, 32'h0));
    tv.push_back(v("opc_prio",  7'h00, 5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'd3,        2'd1, 32'h0));

    resync();
    resync();
    @(negedge clk);
    chk("rst_mem_we", a_mem_we, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_mem_wdata", a_mem_wdata, 0);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_word_count", a_word_count, 0);
    chk("rst_err", a_err, 0);
    chk("rst_err_code", a_err_code, 0);
    resync();
    rst_n = 1'b1;
    resync();

    mem_ack = 1'b1;
    foreach (tv[i]) begin
      set_fields(tv[i].op, tv[i].d, tv[i].f3, tv[i].s1, tv[i].s2, tv[i].f7, tv[i].im);
      open_session(10'h010);
      send(1'b1);
      @(negedge clk);
      chk({tv[i].nm, "_err"}, a_err, (tv[i].code != 2'd0));
      chk({tv[i].nm, "_err_code"}, a_err_code, tv[i].code);
      if (tv[i].code == 2'd0) begin
        chk({tv[i].nm, "_mem_we"}, a_mem_we, 1);
        chk({tv[i].nm, "_mem_addr"}, a_mem_addr, 10'h010);
        chk({tv[i].nm, "_wdata"}, a_mem_wdata, tv[i].wd);
      end else begin
        chk({tv[i].nm, "_no_write"}, a_mem_we, 0);
      end
      wait_done();
      chk({tv[i].nm, "_word_count"}, a_word_count, (tv[i].code == 2'd0) ? 1 : 0);
    end

    // Four back-to-back bundles with memory always accepting.
    exp_w = '{32'h002081B3, 32'h00208463, 32'h001000EF, 32'h123452B7};
    open_session(10'h020);
    wb = q_addr.size();
    db = done_cnt;
    set_fields(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'd0);
    send(1'b0);
    set_fields(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, 32'd8);
    send(1'b0);
    set_fields(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h800);
    send(1'b0);
    set_fields(7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000);
    send(1'b1);
    wait_done();
    resync();
    resync();
    chk("b2b_writes", q_addr.size() - wb, 4);
    for (int k = 0; k < 4; k++) begin
      chk("b2b_addr", (wb + k < q_addr.size()) ? 32'(q_addr[wb+k]) : 32'hFFFF_FFFF, 32'h020 + k);
      chk("b2b_data", (wb + k < q_data.size()) ? q_data[wb+k] : 32'hFFFF_FFFF, exp_w[k]);
    end
    chk("b2b_word_count", a_word_count, 4);
    chk("b2b_done_pulses", done_cnt - db, 1);

    // Stalled write, ignored start, then accept and retire in the same cycle.
    mem_ack = 1'b0;
    open_session(10'h040);
    wb = q_addr.size();
    set_fields(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);
    send(1'b0);
    set_fields(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'd0);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", a_in_ready, 0);
      chk("stall_mem_we", a_mem_we, 1);
      chk("stall_mem_addr", a_mem_addr, 10'h040);
      chk("stall_wdata", a_mem_wdata, 32'h00500093);
      resync();
      start = (k == 0);
      base_addr = 10'h3FF;
    end
    start = 1'b0;
    mem_ack = 1'b1;
    send(1'b1);
    @(negedge clk);
    chk("nobubble_mem_we", a_mem_we, 1);
    chk("nobubble_mem_addr", a_mem_addr, 10'h041);
    chk("nobubble_wdata", a_mem_wdata, 32'h002081B3);
    wait_done();
    chk("stall_word_count", a_word_count, 2);
    chk("stall_writes", q_addr.size() - wb, 2);
    chk("stall_first_addr", (wb < q_addr.size()) ? 32'(q_addr[wb]) : 32'hFFFF_FFFF, 32'h040);

    // Unsupported opcode then out-of-range immediate.
    open_session(10'h080);
    wb = q_addr.size();
    set_fields(7'h7F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd0);
    send(1'b0);
    @(negedge clk);
    chk("e1_err", a_err, 1);
    chk("e1_code", a_err_code, 1);
    chk("e1_no_write", a_mem_we, 0);
    resync();
    set_fields(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h800);
    send(1'b1);
    @(negedge clk);
    chk("e2_err", a_err, 1);
    chk("e2_code", a_err_code, 2);
    chk("e2_no_write", a_mem_we, 0);
    wait_done();
    chk("e_word_count", a_word_count, 0);
    chk("e_writes", q_addr.size() - wb, 0);
    chk("e_err_held", a_err, 1);

    // Address exhaustion on the 2-bit instance.
    use2 = 1'b1;
    open_session(10'd3);
    set_fields(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);
    send(1'b0);
    @(negedge clk);
    chk("full_first_we", b_mem_we, 1);
    chk("full_first_addr", b_mem_addr, 3);
    chk("full_first_wdata", b_mem_wdata, 32'h00500093);
    resync();
    set_fields(7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'h00, 32'd1);
    send(1'b1);
    @(negedge clk);
    chk("full_err", b_err, 1);
    chk("full_code", b_err_code, 3);
    chk("full_no_write", b_mem_we, 0);
    wait_done();
    chk("full_word_count", b_word_count, 1);
    use2 = 1'b0;

    // Reset while a write is pending.
    mem_ack = 1'b0;
    open_session(10'h0C0);
    set_fields(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);
    send(1'b1);
    @(negedge clk);
    chk("pre_rst_mem_we", a_mem_we, 1);
    chk("pre_rst_busy", a_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_we", a_mem_we, 0);
    chk("arst_mem_addr", a_mem_addr, 0);
    chk("arst_mem_wdata", a_mem_wdata, 0);
    chk("arst_in_ready", a_in_ready, 0);
    chk("arst_busy", a_busy, 0);
    chk("arst_done", a_done, 0);
    chk("arst_word_count", a_word_count, 0);
    chk("arst_err", a_err, 0);
    chk("arst_err_code", a_err_code, 0);
    resync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", a_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
